// File: rtl/trig_rx_pkg.sv
// trig_rx_pkg: shared types and constants for the trigger pulse receiver.
package trig_rx_pkg;
    localparam int EV_LINES = 4;
    localparam int EV_TS_WIDTH = 56;
    localparam int WIDTH_SAT = 63;

    typedef enum logic [1:0] {IDLE, HIGH, HOLDOFF} state_t;

    typedef struct packed {
        logic [EV_TS_WIDTH-1:0] timestamp;
        logic [EV_LINES-1:0]    pattern;
        logic [7:0]             seq;
    } event_t;
endpackage

// File: rtl/trig_event_fifo.sv
// trig_event_fifo: first-word-fall-through event FIFO; head reads as zero while empty.
module trig_event_fifo
    import trig_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        push,
    input  logic        pop,
    input  event_t      din,
    output event_t      dout,
    output logic        valid,
    output logic        push_ok,
    output logic [AW:0] count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    event_t mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic do_pop;

    assign valid = count != '0;
    assign do_pop = pop && valid;
    // a full FIFO still takes a push when the head leaves in the same cycle
    assign push_ok = push && (count != FULL || do_pop);
    assign dout = valid ? mem[rd] : '0;

    always_ff @(posedge clk)
        if (push_ok) mem[wr] <= din;

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(do_pop);
        end
endmodule

// File: rtl/trig_pulse_receiver.sv
// trig_pulse_receiver: qualifies trigger pulses by width, timestamps and queues accepted events.
module trig_pulse_receiver
    import trig_rx_pkg::*;
#(
    parameter int N_LINES = EV_LINES,
    parameter int FIFO_DEPTH = 8,
    parameter int MIN_WIDTH = 8,
    parameter int MAX_WIDTH = 24,
    parameter int TS_WIDTH = EV_TS_WIDTH
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [N_LINES-1:0]  trig_in,
    input  logic [7:0]          holdoff_cycles,
    input  logic                ts_clear,
    output logic                ready_out,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [TS_WIDTH-1:0] ev_timestamp,
    output logic [N_LINES-1:0]  ev_pattern,
    output logic [7:0]          ev_seq,
    output logic [15:0]         glitch_cnt,
    output logic [15:0]         overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] READY_MAX = (AW+1)'(FIFO_DEPTH-2);
    localparam logic [5:0] W_MIN = 6'(MIN_WIDTH);
    localparam logic [5:0] W_MAX = 6'(MAX_WIDTH);
    localparam logic [5:0] W_SAT = 6'(WIDTH_SAT);

    state_t state, next;
    logic [N_LINES-1:0] s1, s2, pat, pat_n;
    logic [TS_WIDTH-1:0] ts, ts_cap, ts_cap_n;
    logic [5:0] width, width_n;
    logic [7:0] seq, hold, hold_n;
    logic [AW:0] count, count_next;
    logic any_hi, in_range, push, push_ok, pop, glitch_inc, ovf_inc;
    event_t wdata, head;

    assign any_hi = |s2;
    assign pop = ev_valid && ev_ready;
    assign wdata = '{timestamp: ts_cap, pattern: pat, seq: seq};
    assign ev_timestamp = head.timestamp;
    assign ev_pattern = head.pattern;
    assign ev_seq = head.seq;

    trig_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .nrst(nrst), .push(push), .pop(pop), .din(wdata),
        .dout(head), .valid(ev_valid), .push_ok(push_ok), .count(count)
    );

    always_comb begin
        next = state;
        width_n = width;
        pat_n = pat;
        ts_cap_n = ts_cap;
        hold_n = hold;
        push = 1'b0;
        glitch_inc = 1'b0;
        ovf_inc = 1'b0;
        in_range = width >= W_MIN && width <= W_MAX;
        case (state)
            IDLE:
                if (any_hi) begin
                    next = HIGH;
                    ts_cap_n = ts;
                    pat_n = s2;
                    width_n = 6'd1;
                end
            HIGH:
                if (any_hi) begin
                    width_n = width == W_SAT ? width : width + 6'd1;
                    pat_n = pat | s2;
                end else if (in_range) begin
                    push = 1'b1;
                    ovf_inc = !push_ok;
                    hold_n = holdoff_cycles;
                    next = holdoff_cycles == 8'd0 ? IDLE : HOLDOFF;
                end else begin
                    glitch_inc = 1'b1;
                    next = IDLE;
                end
            HOLDOFF: begin
                hold_n = hold - 8'd1;
                next = hold == 8'd1 ? IDLE : HOLDOFF;
            end
            default: next = IDLE;
        endcase
        count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state <= IDLE;
            s1 <= '0;
            s2 <= '0;
            ts <= '0;
            ts_cap <= '0;
            pat <= '0;
            width <= '0;
            hold <= '0;
            seq <= '0;
            glitch_cnt <= '0;
            overflow_cnt <= '0;
            ready_out <= 1'b0;
        end else begin
            s1 <= trig_in;
            s2 <= s1;
            ts <= ts_clear ? '0 : ts + 1'b1;
            state <= next;
            ts_cap <= ts_cap_n;
            pat <= pat_n;
            width <= width_n;
            hold <= hold_n;
            seq <= seq + {7'd0, push_ok};
            glitch_cnt <= glitch_cnt + {15'd0, glitch_inc && glitch_cnt != 16'hFFFF};
            overflow_cnt <= overflow_cnt + {15'd0, ovf_inc && overflow_cnt != 16'hFFFF};
            ready_out <= next == IDLE && count_next <= READY_MAX;
        end
endmodule

// File: doc/trig_pulse_receiver.md
Name: trig_pulse_receiver

Overview:
- Downstream end of the trigger-board coax/LVDS trigger outputs.
- Receives the fixed-width trigger pulses and qualifies them by pulse width.
- Timestamps each accepted trigger with a free-running clock counter, tags it with the output-line pattern and a sequence number, and buffers it in a small FWFT FIFO for readout.
- Drives a ready (not-busy) line back to the trigger board, which gates further triggers.

Parameters:
- N_LINES, 4: number of trigger lines received.
- FIFO_DEPTH, 8: event FIFO entries; power of 2, at least 4.
- MIN_WIDTH, 8: minimum accepted pulse width, in clk cycles.
- MAX_WIDTH, 24: maximum accepted pulse width; must be less than 63.
- TS_WIDTH, 56: timestamp counter width.

Ports:
- clk, input, 1: system clock; all logic is in this domain.
- nrst, input, 1: asynchronous active-low reset.
- trig_in, input, N_LINES: raw trigger lines, active-high, asynchronous to clk.
- holdoff_cycles, input, 8: dead time after an accepted trigger, in clk cycles.
- ts_clear, input, 1: synchronous clear of the timestamp counter.
- ready_out, output, 1: registered; 1 means able to accept a trigger.
- ev_valid, output, 1: FIFO head is valid.
- ev_ready, input, 1: consumer pop; a pop occurs when ev_valid and ev_ready are both 1.
- ev_timestamp, output, TS_WIDTH: timestamp of the head event.
- ev_pattern, output, N_LINES: OR of all lines seen during the pulse.
- ev_seq, output, 8: sequence number of the head event.
- glitch_cnt, output, 16: count of rejected pulses (width out of range); saturates.
- overflow_cnt, output, 16: count of valid pulses dropped because the FIFO was full; saturates.

Behaviour:
- Reset (asynchronous, nrst=0) forces all state and counters to zero:
  - FSM goes to IDLE;
  - the FIFO is emptied;
  - ev_valid=0, ready_out=0, and all data outputs are 0.
  - ready_out rises on the first clk edge after nrst is released.
- Synchronisation: trig_in passes through a 2-flop synchroniser per line; any_hi is the OR of the synchronised lines. Every timing statement below is relative to the synchronised value.
- Timestamp counter: free-running, increments every cycle and wraps to 0 at 2^TS_WIDTH.
  - ts_clear=1 loads 0 at the next edge.
  - If a capture happens in the same cycle, it takes the pre-clear value.
- FSM states: IDLE, HIGH, HOLDOFF.
- IDLE:
  - When any_hi=1, latch ts_cap from the current counter value, set pat from the synchronised lines, set width=1, and go to HIGH.
  - Pin-to-capture latency is 2 cycles; the bench compensates for it.
- HIGH while any_hi=1:
  - width increments and saturates at 63;
  - pat accumulates the OR of the lines.
- HIGH when any_hi=0 (pulse end):
  - If width is in [MIN_WIDTH, MAX_WIDTH] and the FIFO accepts a push: write {ts_cap, pat, seq}, then increment seq (8-bit, wraps 255 to 0). Go to HOLDOFF, or to IDLE if holdoff_cycles=0.
  - If width is in range but the FIFO is full: increment overflow_cnt, leave seq unchanged, go to HOLDOFF (or IDLE as above).
  - If width is out of range: increment glitch_cnt, go to IDLE (no holdoff).
- HOLDOFF:
  - Load a down-counter with holdoff_cycles on entry.
  - Decrement once per cycle; go to IDLE on the cycle the count reaches 0.
  - Pulses arriving during HOLDOFF are ignored entirely and not counted.
  - A line still high when HOLDOFF exits is treated as a new rising edge in IDLE.
- FIFO: first-word-fall-through.
  - A push is accepted when count < FIFO_DEPTH, or when a pop happens in the same cycle.
  - Simultaneous push and pop on an empty FIFO: the pop is ignored because ev_valid=0; the push lands.
  - ev_valid is 1 exactly when count > 0. Head data is stable while ev_valid=1 and ev_ready=0.
  - Push-to-ev_valid latency is 1 cycle. Pin falling edge to ev_valid is 3 clk edges.
- ready_out is registered and equals (next state is IDLE) AND (count after this cycle ≤ FIFO_DEPTH-2). It therefore drops in the same cycle HIGH is entered.
- glitch_cnt and overflow_cnt saturate at 0xFFFF. They clear only on reset.

Decomposition:
- Package trig_rx_pkg holds:
  - the state enum {IDLE, HIGH, HOLDOFF};
  - the typedef event_t with fields {timestamp TS_WIDTH, pattern N_LINES, seq 8};
  - the constant WIDTH_SAT = 63.
- Sub-module trig_event_fifo: a parameterised FWFT FIFO of event_t with push/pop/count ports.
- The FSM, synchroniser and counters live in the top.

Test Plan:
- Single 16-cycle pulse on line 0, holdoff_cycles=10, ts_clear pulsed at t0 → one event: pattern=4'b0001, seq=0, timestamp = t0-relative edge + 2; ready_out low for 16 + 10 cycles, then high.
- Pulses of width 5 and 30 → no events, glitch_cnt=2, seq unchanged; widths exactly 8 and 24 → both accepted.
- Overlapping pulses: line 1 for cycles 0–15, line 3 for cycles 4–19 → a single event with pattern=4'b1010.
- ev_ready=0, 10 valid pulses, holdoff_cycles=0 → FIFO holds 8 events, seq 0–7; ready_out=0 once count ≥ 7; overflow_cnt=2 (the bench ignores ready_out here); then drain → ev_seq 0..7 in order.
- 260 accepted pulses with continuous pop → ev_seq wraps 255 to 0; timestamp strictly increasing; preload the counter near 2^56-1 via force → timestamp wraps to 0.
- nrst asserted while in HIGH with 3 events queued → outputs zero immediately; after release: ev_valid=0, seq=0, ready_out=1 one edge later; the still-high line is accepted as a new pulse.
